// File: rtl/cubehash_msg_sched_if.sv
// Byte-stream and block hand-off signals for the CubeHash message scheduler.
// The scheduler takes the slave side; the host/core environment takes the master side.
interface cubehash_msg_sched_if #(
  parameter int BLOCK_BYTES = 32,
  parameter int CNT_W       = 16
);
  logic                     clr;
  logic [7:0]               in_byte;
  logic                     in_valid;
  logic                     in_ready;
  logic                     eom;
  logic [BLOCK_BYTES*8-1:0] blk_data;
  logic                     blk_valid;
  logic                     blk_ready;
  logic                     blk_final;
  logic [CNT_W-1:0]         blk_count;
  logic                     busy;

  modport master (
    output clr, in_byte, in_valid, eom, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_final, blk_count, busy
  );

  modport slave (
    input  clr, in_byte, in_valid, eom, blk_ready,
    output in_ready, blk_data, blk_valid, blk_final, blk_count, busy
  );
endinterface

// File: rtl/cubehash_msg_sched.sv
// CubeHash message scheduler: packs a byte stream into 256-bit blocks, applies
// 0x80/zero padding and offers each block (final one flagged) to the round core.
module cubehash_msg_sched #(
  parameter int         BLOCK_BYTES = 32,
  parameter logic [7:0] PAD_BYTE    = 8'h80,
  parameter int         CNT_W       = 16
) (
  input logic                 clk,
  input logic                 rst_p,
  cubehash_msg_sched_if.slave bus
);
  localparam int IDX_W = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_PAD   = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] pad_idx_q;
  logic             pad_pend_q;
  logic             final_q;
  logic             busy_q;
  logic [CNT_W-1:0] blk_count_q;
  logic [7:0]       blk_buf [BLOCK_BYTES];

  logic byte_acc;
  logic blk_acc;

  assign byte_acc = (state_q == S_FILL) && bus.in_valid;
  assign blk_acc  = (state_q == S_ISSUE) && bus.blk_ready;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // A full block always goes out before padding, even when eom rides on its last byte.
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = S_FILL;
    end else begin
      case (state_q)
        S_FILL: begin
          if (byte_acc) begin
            if (cnt_q == LAST_IDX) begin
              state_d = S_ISSUE;
            end else if (bus.eom) begin
              state_d = S_PAD;
            end
          end else if (bus.eom) begin
            state_d = S_PAD;
          end
        end
        S_PAD: begin
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          if (bus.blk_ready) begin
            if (final_q) begin
              state_d = S_FILL;
            end else if (pad_pend_q) begin
              state_d = S_PAD;
            end else begin
              state_d = S_FILL;
            end
          end
        end
        default: begin
          state_d = S_FILL;
        end
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == S_FILL);
    bus.blk_valid = (state_q == S_ISSUE);
    bus.blk_final = (state_q == S_ISSUE) && final_q;
    bus.blk_count = blk_count_q;
    bus.busy      = busy_q;
    bus.blk_data  = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      bus.blk_data[BLOCK_BYTES*8-1-8*k -: 8] = blk_buf[k];
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      cnt_q       <= '0;
      pad_idx_q   <= '0;
      pad_pend_q  <= 1'b0;
      final_q     <= 1'b0;
      busy_q      <= 1'b0;
      blk_count_q <= '0;
    end else if (bus.clr) begin
      cnt_q       <= '0;
      pad_pend_q  <= 1'b0;
      final_q     <= 1'b0;
      busy_q      <= 1'b0;
      blk_count_q <= '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (byte_acc) begin
            cnt_q  <= cnt_q + IDX_W'(1);
            busy_q <= 1'b1;
            if (cnt_q == LAST_IDX) begin
              final_q <= 1'b0;
              if (bus.eom) begin
                pad_pend_q <= 1'b1;
              end
            end else if (bus.eom) begin
              pad_idx_q <= cnt_q + IDX_W'(1);
            end
          end else if (bus.eom) begin
            pad_idx_q <= cnt_q;
            busy_q    <= 1'b1;
          end
        end
        S_PAD: begin
          final_q <= 1'b1;
        end
        S_ISSUE: begin
          if (bus.blk_ready) begin
            cnt_q <= '0;
            if (final_q) begin
              busy_q      <= 1'b0;
              blk_count_q <= '0;
              final_q     <= 1'b0;
            end else begin
              if (blk_count_q != {CNT_W{1'b1}}) begin
                blk_count_q <= blk_count_q + CNT_W'(1);
              end
              if (pad_pend_q) begin
                pad_pend_q <= 1'b0;
                pad_idx_q  <= '0;
              end
            end
          end
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  // Stale bytes from earlier blocks stay put; data or padding always overwrites them before issue.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int k = 0; k < BLOCK_BYTES; k++) begin
        blk_buf[k] <= 8'h00;
      end
    end else if (!bus.clr) begin
      if (byte_acc) begin
        blk_buf[cnt_q] <= bus.in_byte;
      end else if (state_q == S_PAD) begin
        for (int k = 0; k < BLOCK_BYTES; k++) begin
          if (IDX_W'(k) == pad_idx_q) begin
            blk_buf[k] <= PAD_BYTE;
          end else if (IDX_W'(k) > pad_idx_q) begin
            blk_buf[k] <= 8'h00;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cubehash_msg_sched.sv
// Scoreboard bench for the CubeHash message scheduler: directed messages push
// hand-computed blocks into a queue and a negedge monitor checks every hand-off.
module tb_cubehash_msg_sched;
  logic clk;
  logic rst_p;

  cubehash_msg_sched_if #(.BLOCK_BYTES(32), .CNT_W(16)) bus ();

  cubehash_msg_sched #(.BLOCK_BYTES(32), .PAD_BYTE(8'h80), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (bus)
  );

  typedef struct {
    logic [255:0] data;
    logic         is_final;
    logic [15:0]  count;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectBlock(input logic [255:0] data, input logic is_final, input logic [15:0] count);
    exp_t e;
    e.data     = data;
    e.is_final = is_final;
    e.count    = count;
    expQ.push_back(e);
  endtask

  // Every hand-off the core would see is popped and compared here.
  always @(negedge clk) begin
    if (!rst_p && !bus.clr && bus.blk_valid && bus.blk_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_block", 256'd1, 256'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("blk_data", bus.blk_data, e.data);
        checkOutput("blk_final", {255'd0, bus.blk_final}, {255'd0, e.is_final});
        checkOutput("blk_count", {240'd0, bus.blk_count}, {240'd0, e.count});
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input logic last);
    int n = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    bus.eom      = last;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) checkOutput("in_ready_timeout", 256'd0, 256'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.eom      = 1'b0;
  endtask

  task automatic sendEom();
    int n = 0;
    bus.in_valid = 1'b0;
    bus.eom      = 1'b1;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) checkOutput("eom_timeout", 256'd0, 256'd1);
    @(posedge clk); #1;
    bus.eom = 1'b0;
  endtask

  task automatic waitBlkValid(input string name);
    int n = 0;
    while (!bus.blk_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.blk_valid) checkOutput(name, 256'd0, 256'd1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((bus.busy || bus.blk_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, {255'd0, bus.busy}, 256'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, {255'd0, bus.in_ready}, 256'd1);
    checkOutput({tag, "_blk_valid"}, {255'd0, bus.blk_valid}, 256'd0);
    checkOutput({tag, "_blk_final"}, {255'd0, bus.blk_final}, 256'd0);
    checkOutput({tag, "_blk_data"}, bus.blk_data, 256'd0);
    checkOutput({tag, "_blk_count"}, {240'd0, bus.blk_count}, 256'd0);
    checkOutput({tag, "_busy"}, {255'd0, bus.busy}, 256'd0);
  endtask

  initial begin
    rst_p         = 1'b1;
    bus.clr       = 1'b0;
    bus.in_byte   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.eom       = 1'b0;
    bus.blk_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_p = 1'b0;
    @(posedge clk); #1;

    $display("[TB] T1: five-byte message");
    expectBlock({40'h0102030405, 8'h80, 208'h0}, 1'b1, 16'd0);
    applyStimulus(8'h01, 1'b0);
    checkOutput("t1_busy_rise", {255'd0, bus.busy}, 256'd1);
    for (int i = 2; i <= 5; i++) applyStimulus(8'(i), i == 5);
    waitIdle("t1_busy_fall");

    $display("[TB] T2: 32-byte message adds a padding block");
    expectBlock(256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F, 1'b0, 16'd0);
    expectBlock({8'h80, 248'h0}, 1'b1, 16'd1);
    for (int i = 0; i < 32; i++) applyStimulus(8'(i), i == 31);
    waitIdle("t2_idle");

    $display("[TB] T3: empty message");
    rst_p = 1'b1;
    @(posedge clk); #1;
    rst_p = 1'b0;
    expectBlock({8'h80, 248'h0}, 1'b1, 16'd0);
    sendEom();
    waitIdle("t3_idle");

    $display("[TB] T4: 70 bytes with stalled core");
    expectBlock(256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20, 1'b0, 16'd0);
    expectBlock(256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20, 1'b0, 16'd1);
    expectBlock({48'h010203040506, 8'h80, 200'h0}, 1'b1, 16'd2);
    bus.blk_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 70; i++) applyStimulus(8'((i % 32) + 1), i == 69);
      end
      begin
        for (int b = 0; b < 3; b++) begin
          logic [255:0] snapData;
          logic         snapFinal;
          logic         stable;
          logic         rdyLow;
          waitBlkValid("t4_blk_valid_timeout");
          snapData  = bus.blk_data;
          snapFinal = bus.blk_final;
          stable    = 1'b1;
          rdyLow    = !bus.in_ready;
          repeat (10) begin
            @(posedge clk); #1;
            if (bus.blk_data !== snapData || bus.blk_final !== snapFinal || !bus.blk_valid) stable = 1'b0;
            if (bus.in_ready) rdyLow = 1'b0;
          end
          checkOutput("t4_stable", {255'd0, stable}, 256'd1);
          checkOutput("t4_in_ready_low", {255'd0, rdyLow}, 256'd1);
          bus.blk_ready = 1'b1;
          @(posedge clk); #1;
          bus.blk_ready = 1'b0;
        end
      end
    join
    waitIdle("t4_idle");

    $display("[TB] T5: asynchronous reset mid-block and mid-handshake");
    bus.blk_ready = 1'b1;
    for (int i = 0; i < 17; i++) applyStimulus(8'hE0 + 8'(i), 1'b0);
    #2 rst_p = 1'b1;
    #1 checkResetOutputs("t5_midblock");
    @(posedge clk); #1;
    rst_p = 1'b0;
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 32; i++) applyStimulus(8'h3C, 1'b0);
    waitBlkValid("t5_blk_valid_timeout");
    #2 rst_p = 1'b1;
    #1 checkResetOutputs("t5_stalled");
    @(posedge clk); #1;
    rst_p = 1'b0;
    bus.blk_ready = 1'b1;
    expectBlock({24'hAABBCC, 8'h80, 224'h0}, 1'b1, 16'd0);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    applyStimulus(8'hCC, 1'b1);
    waitIdle("t5_idle");

    $display("[TB] T6: clr drops an offered block");
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 32; i++) applyStimulus(8'h55, 1'b0);
    waitBlkValid("t6_blk_valid_timeout");
    bus.clr       = 1'b1;
    bus.blk_ready = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    checkOutput("t6_blk_valid", {255'd0, bus.blk_valid}, 256'd0);
    checkOutput("t6_in_ready", {255'd0, bus.in_ready}, 256'd1);
    checkOutput("t6_busy", {255'd0, bus.busy}, 256'd0);
    checkOutput("t6_blk_count", {240'd0, bus.blk_count}, 256'd0);
    expectBlock({16'h1122, 8'h80, 232'h0}, 1'b1, 16'd0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b1);
    waitIdle("t6_idle");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", 256'(expQ.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
